// File: rtl/branch_exec_unit_if.sv
// Issue bus from the branch reservation station plus the CDB3, ROB redirect and
// predictor-update outputs of the branch execution unit.
interface branch_exec_unit_if #(
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned OP_W   = 6
);
  logic              Branch_en_i;
  logic [OP_W-1:0]   op_i;
  logic [DATA_W-1:0] reg1_i;
  logic [DATA_W-1:0] reg2_i;
  logic [DATA_W-1:0] imm_i;
  logic [ADDR_W-1:0] pc_i;
  logic              bp_i;
  logic [TAG_W-1:0]  des_i;

  logic              cdb_en_o;
  logic [TAG_W-1:0]  cdb_tag_o;
  logic [DATA_W-1:0] cdb_data_o;
  logic              jump_o;
  logic [ADDR_W-1:0] target_o;
  logic              mispredict_o;
  logic              bpu_en_o;
  logic [ADDR_W-1:0] bpu_pc_o;
  logic              bpu_taken_o;

  modport master (
    output Branch_en_i, op_i, reg1_i, reg2_i, imm_i, pc_i, bp_i, des_i,
    input  cdb_en_o, cdb_tag_o, cdb_data_o, jump_o, target_o, mispredict_o,
           bpu_en_o, bpu_pc_o, bpu_taken_o
  );

  modport slave (
    input  Branch_en_i, op_i, reg1_i, reg2_i, imm_i, pc_i, bp_i, des_i,
    output cdb_en_o, cdb_tag_o, cdb_data_o, jump_o, target_o, mispredict_o,
           bpu_en_o, bpu_pc_o, bpu_taken_o
  );
endinterface

// File: rtl/branch_exec_unit.sv
// Two-stage branch/jump execution unit: stage 1 resolves direction, target and
// misprediction; stage 2 registers the CDB3, redirect and predictor-update outputs.
module branch_exec_unit #(
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned OP_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               clear,
  branch_exec_unit_if.slave  bus
);

  localparam logic [OP_W-1:0] OpJal  = OP_W'(1);
  localparam logic [OP_W-1:0] OpJalr = OP_W'(2);
  localparam logic [OP_W-1:0] OpBeq  = OP_W'(3);
  localparam logic [OP_W-1:0] OpBne  = OP_W'(4);
  localparam logic [OP_W-1:0] OpBlt  = OP_W'(5);
  localparam logic [OP_W-1:0] OpBge  = OP_W'(6);
  localparam logic [OP_W-1:0] OpBltu = OP_W'(7);
  localparam logic [OP_W-1:0] OpBgeu = OP_W'(8);

  // Stage-1 combinational resolve
  logic              taken_d;
  logic              is_cond_d;
  logic              mispredict_d;
  logic [ADDR_W-1:0] target_d;
  logic [DATA_W-1:0] link_d;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] pc_plus_imm;
  logic [ADDR_W-1:0] jalr_target;

  assign pc_plus4    = bus.pc_i + ADDR_W'(4);
  assign pc_plus_imm = bus.pc_i + ADDR_W'(bus.imm_i);
  assign jalr_target = ADDR_W'(bus.reg1_i + bus.imm_i) & ~ADDR_W'(1);

  always_comb begin
    taken_d      = 1'b0;
    is_cond_d    = 1'b0;
    mispredict_d = 1'b0;
    target_d     = pc_plus4;
    link_d       = '0;
    case (bus.op_i)
      OpJal: begin
        taken_d      = 1'b1;
        target_d     = pc_plus_imm;
        link_d       = DATA_W'(pc_plus4);
        mispredict_d = ~bus.bp_i;
      end
      OpJalr: begin
        taken_d      = 1'b1;
        target_d     = jalr_target;
        link_d       = DATA_W'(pc_plus4);
        // No indirect-target prediction exists, so every JALR redirects.
        mispredict_d = 1'b1;
      end
      OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu: begin
        is_cond_d = 1'b1;
        case (bus.op_i)
          OpBeq:   taken_d = (bus.reg1_i == bus.reg2_i);
          OpBne:   taken_d = (bus.reg1_i != bus.reg2_i);
          OpBlt:   taken_d = ($signed(bus.reg1_i) < $signed(bus.reg2_i));
          OpBge:   taken_d = ($signed(bus.reg1_i) >= $signed(bus.reg2_i));
          OpBltu:  taken_d = (bus.reg1_i < bus.reg2_i);
          default: taken_d = (bus.reg1_i >= bus.reg2_i);
        endcase
        target_d     = taken_d ? pc_plus_imm : pc_plus4;
        mispredict_d = taken_d ^ bus.bp_i;
      end
      default: ;
    endcase
  end

  // Stage-1 registers
  logic              s1_valid_q;
  logic [TAG_W-1:0]  s1_tag_q;
  logic              s1_taken_q;
  logic [ADDR_W-1:0] s1_target_q;
  logic [DATA_W-1:0] s1_link_q;
  logic              s1_mispredict_q;
  logic              s1_is_cond_q;
  logic [ADDR_W-1:0] s1_pc_q;

  // Stage-2 (output) registers
  logic              cdb_en_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [DATA_W-1:0] cdb_data_q;
  logic              jump_q;
  logic [ADDR_W-1:0] target_q;
  logic              mispredict_q;
  logic              bpu_en_q;
  logic [ADDR_W-1:0] bpu_pc_q;
  logic              bpu_taken_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      s1_valid_q      <= 1'b0;
      s1_tag_q        <= '0;
      s1_taken_q      <= 1'b0;
      s1_target_q     <= '0;
      s1_link_q       <= '0;
      s1_mispredict_q <= 1'b0;
      s1_is_cond_q    <= 1'b0;
      s1_pc_q         <= '0;
      cdb_en_q        <= 1'b0;
      cdb_tag_q       <= '0;
      cdb_data_q      <= '0;
      jump_q          <= 1'b0;
      target_q        <= '0;
      mispredict_q    <= 1'b0;
      bpu_en_q        <= 1'b0;
      bpu_pc_q        <= '0;
      bpu_taken_q     <= 1'b0;
    end else if (rdy) begin
      s1_valid_q      <= bus.Branch_en_i;
      s1_tag_q        <= bus.des_i;
      s1_taken_q      <= taken_d;
      s1_target_q     <= target_d;
      s1_link_q       <= link_d;
      s1_mispredict_q <= mispredict_d;
      s1_is_cond_q    <= is_cond_d;
      s1_pc_q         <= bus.pc_i;

      cdb_en_q        <= s1_valid_q;
      bpu_en_q        <= s1_valid_q & s1_is_cond_q;
      if (s1_valid_q) begin
        cdb_tag_q    <= s1_tag_q;
        cdb_data_q   <= s1_link_q;
        jump_q       <= s1_taken_q;
        target_q     <= s1_target_q;
        mispredict_q <= s1_mispredict_q;
        bpu_pc_q     <= s1_pc_q;
        bpu_taken_q  <= s1_taken_q;
      end else begin
        cdb_tag_q    <= '0;
        cdb_data_q   <= '0;
        jump_q       <= 1'b0;
        target_q     <= '0;
        mispredict_q <= 1'b0;
        bpu_pc_q     <= '0;
        bpu_taken_q  <= 1'b0;
      end
    end
  end

  assign bus.cdb_en_o     = cdb_en_q;
  assign bus.cdb_tag_o    = cdb_tag_q;
  assign bus.cdb_data_o   = cdb_data_q;
  assign bus.jump_o       = jump_q;
  assign bus.target_o     = target_q;
  assign bus.mispredict_o = mispredict_q;
  assign bus.bpu_en_o     = bpu_en_q;
  assign bus.bpu_pc_o     = bpu_pc_q;
  assign bus.bpu_taken_o  = bpu_taken_q;

endmodule

// File: tb/tb_branch_exec_unit.sv
// Directed-vector bench for branch_exec_unit: each scenario task drives issues and
// checks the registered outputs against hand-computed values.
module tb_branch_exec_unit;

  localparam logic [5:0] OpJal  = 6'd1;
  localparam logic [5:0] OpJalr = 6'd2;
  localparam logic [5:0] OpBeq  = 6'd3;
  localparam logic [5:0] OpBne  = 6'd4;
  localparam logic [5:0] OpBlt  = 6'd5;
  localparam logic [5:0] OpBge  = 6'd6;
  localparam logic [5:0] OpBltu = 6'd7;
  localparam logic [5:0] OpBgeu = 6'd8;

  // {cdb_en, tag, data, jump, target, mispredict, bpu_en, bpu_pc, bpu_taken}
  typedef logic [104:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  logic clear = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  branch_exec_unit_if #(.TAG_W(4), .DATA_W(32), .ADDR_W(32), .OP_W(6)) bus ();

  branch_exec_unit #(.TAG_W(4), .DATA_W(32), .ADDR_W(32), .OP_W(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t outs();
    return {bus.cdb_en_o, bus.cdb_tag_o, bus.cdb_data_o, bus.jump_o, bus.target_o,
            bus.mispredict_o, bus.bpu_en_o, bus.bpu_pc_o, bus.bpu_taken_o};
  endfunction

  function automatic vec_t mk(logic en, logic [3:0] tag, logic [31:0] data, logic jump,
                              logic [31:0] tgt, logic misp, logic ben, logic [31:0] bpc,
                              logic btk);
    return {en, tag, data, jump, tgt, misp, ben, bpc, btk};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] imm, input logic [31:0] pc, input logic bp,
                       input logic [3:0] tag);
    bus.Branch_en_i = 1'b1;
    bus.op_i = op;
    bus.reg1_i = r1;
    bus.reg2_i = r2;
    bus.imm_i = imm;
    bus.pc_i = pc;
    bus.bp_i = bp;
    bus.des_i = tag;
  endtask

  task automatic idle();
    bus.Branch_en_i = 1'b0;
    bus.op_i = '0;
    bus.reg1_i = '0;
    bus.reg2_i = '0;
    bus.imm_i = '0;
    bus.pc_i = '0;
    bus.bp_i = 1'b0;
    bus.des_i = '0;
  endtask

  task automatic test_reset();
    vec_t got;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    got = outs();
    n_cmp++;
    if (got !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got=%h exp=0", got);
    end
  endtask

  task automatic test_beq();
    vec_t got, exp;
    issue(OpBeq, 32'd5, 32'd5, 32'h20, 32'h100, 1'b0, 4'd3);
    tick();
    idle();
    n_cmp++;
    if (bus.cdb_en_o !== 1'b0) begin
      n_err++;
      $display("FAIL beq_early got=%b exp=0", bus.cdb_en_o);
    end
    tick();
    got = outs();
    exp = mk(1'b1, 4'd3, 32'h0, 1'b1, 32'h120, 1'b1, 1'b1, 32'h100, 1'b1);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL beq_result got=%h exp=%h", got, exp);
    end
    tick();
    n_cmp++;
    if (bus.cdb_en_o !== 1'b0) begin
      n_err++;
      $display("FAIL beq_single_pulse got=%b exp=0", bus.cdb_en_o);
    end
  endtask

  task automatic test_back_to_back();
    vec_t got, exp;
    issue(OpBlt, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h400, 1'b1, 4'd1);
    tick();
    issue(OpBltu, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h404, 1'b1, 4'd2);
    tick();
    got = outs();
    exp = mk(1'b1, 4'd1, 32'h0, 1'b1, 32'h410, 1'b0, 1'b1, 32'h400, 1'b1);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL blt_signed got=%h exp=%h", got, exp);
    end
    issue(OpBge, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h100, 32'h900, 1'b0, 4'hA);
    tick();
    got = outs();
    exp = mk(1'b1, 4'd2, 32'h0, 1'b0, 32'h408, 1'b1, 1'b1, 32'h404, 1'b0);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL bltu_unsigned got=%h exp=%h", got, exp);
    end
    idle();
    tick();
    got = outs();
    exp = mk(1'b1, 4'hA, 32'h0, 1'b0, 32'h904, 1'b0, 1'b1, 32'h900, 1'b0);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL bge_signed got=%h exp=%h", got, exp);
    end
    tick();
    n_cmp++;
    if (bus.cdb_en_o !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain got=%b exp=0", bus.cdb_en_o);
    end
  endtask

  task automatic test_jumps();
    vec_t got, exp;
    issue(OpJalr, 32'h1003, 32'h0, 32'h4, 32'h200, 1'b1, 4'd7);
    tick();
    issue(OpJal, 32'h0, 32'h0, 32'hFFFF_FFF8, 32'h300, 1'b1, 4'd8);
    tick();
    got = outs();
    exp = mk(1'b1, 4'd7, 32'h204, 1'b1, 32'h1006, 1'b1, 1'b0, 32'h200, 1'b1);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL jalr_result got=%h exp=%h", got, exp);
    end
    idle();
    tick();
    got = outs();
    exp = mk(1'b1, 4'd8, 32'h304, 1'b1, 32'h2F8, 1'b0, 1'b0, 32'h300, 1'b1);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL jal_result got=%h exp=%h", got, exp);
    end
    tick();
  endtask

  task automatic test_unknown_op();
    vec_t got, exp;
    issue(6'h3F, 32'h7, 32'h7, 32'h40, 32'h700, 1'b1, 4'd6);
    tick();
    idle();
    tick();
    got = outs();
    exp = mk(1'b1, 4'd6, 32'h0, 1'b0, 32'h704, 1'b0, 1'b0, 32'h700, 1'b0);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL unknown_op got=%h exp=%h", got, exp);
    end
    tick();
  endtask

  task automatic test_stall();
    vec_t got, exp;
    issue(OpBne, 32'd1, 32'd2, 32'h40, 32'h500, 1'b0, 4'd5);
    tick();
    rdy = 1'b0;
    // An issue presented while stalled must never be captured.
    issue(OpJal, 32'h0, 32'h0, 32'h10, 32'hA00, 1'b0, 4'd9);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (bus.cdb_en_o !== 1'b0) begin
        n_err++;
        $display("FAIL stall_frozen[%0d] got=%b exp=0", i, bus.cdb_en_o);
      end
    end
    idle();
    rdy = 1'b1;
    tick();
    got = outs();
    exp = mk(1'b1, 4'd5, 32'h0, 1'b1, 32'h540, 1'b1, 1'b1, 32'h500, 1'b1);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL stall_resume got=%h exp=%h", got, exp);
    end
    rdy = 1'b0;
    tick();
    got = outs();
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL stall_hold got=%h exp=%h", got, exp);
    end
    rdy = 1'b1;
    tick();
    n_cmp++;
    if (bus.cdb_en_o !== 1'b0) begin
      n_err++;
      $display("FAIL stall_no_ghost got=%b exp=0", bus.cdb_en_o);
    end
  endtask

  task automatic test_clear();
    vec_t got, exp;
    issue(OpBeq, 32'd1, 32'd1, 32'h4, 32'h800, 1'b1, 4'd1);
    tick();
    issue(OpBne, 32'd1, 32'd2, 32'h8, 32'h804, 1'b0, 4'd2);
    tick();
    issue(OpJal, 32'd0, 32'd0, 32'hC, 32'h808, 1'b0, 4'd3);
    clear = 1'b1;
    got = outs();
    exp = mk(1'b1, 4'd1, 32'h0, 1'b1, 32'h804, 1'b0, 1'b1, 32'h800, 1'b1);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL clear_first_visible got=%h exp=%h", got, exp);
    end
    tick();
    clear = 1'b0;
    idle();
    got = outs();
    n_cmp++;
    if (got !== '0) begin
      n_err++;
      $display("FAIL clear_outputs got=%h exp=0", got);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (bus.cdb_en_o !== 1'b0) begin
        n_err++;
        $display("FAIL clear_no_pulse[%0d] got=%b exp=0", i, bus.cdb_en_o);
      end
    end
  endtask

  task automatic test_reset_midstream();
    vec_t got, exp;
    issue(OpBeq, 32'd2, 32'd2, 32'h4, 32'hB00, 1'b0, 4'd1);
    tick();
    issue(OpJal, 32'd0, 32'd0, 32'h4, 32'hB04, 1'b0, 4'd2);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got = outs();
    n_cmp++;
    if (got !== '0) begin
      n_err++;
      $display("FAIL rst_mid_outputs got=%h exp=0", got);
    end
    tick();
    n_cmp++;
    if (bus.cdb_en_o !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_no_pulse got=%b exp=0", bus.cdb_en_o);
    end
    issue(OpBgeu, 32'd3, 32'd3, 32'h8, 32'h600, 1'b0, 4'd4);
    tick();
    idle();
    tick();
    got = outs();
    exp = mk(1'b1, 4'd4, 32'h0, 1'b1, 32'h608, 1'b1, 1'b1, 32'h600, 1'b1);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL bgeu_after_rst got=%h exp=%h", got, exp);
    end
    tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_beq();
    test_back_to_back();
    test_jumps();
    test_unknown_op();
    test_stall();
    test_clear();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_exec_unit.md
Name: branch_exec_unit

Overview:
- Execution stage directly downstream of the branch reservation station.
- Consumes one issued branch or jump per cycle: op, two operand values, immediate, pc, predicted-taken bit, ROB tag.
- Resolves direction and target, then produces three outputs:
  - the link-value broadcast on CDB3;
  - the redirect/mispredict report for the ROB;
  - the predictor-update record for fetch.
- Two-stage pipeline (resolve, broadcast) with rdy stall and clear flush.

Parameters:
TAG_W, 4, ROB tag width (matches `TagBus)
DATA_W, 32, operand/data width (matches `DataBus)
ADDR_W, 32, pc width (matches `AddrBus)
OP_W, 6, op code width (matches `OpBus)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; low freezes all state
clear  in  1  pipeline flush from ROB on mispredict commit
Branch_en_i  in  1  issue valid from branch RS
op_i  in  OP_W  `JAL/`JALR/`BEQ/`BNE/`BLT/`BGE/`BLTU/`BGEU
reg1_i  in  DATA_W  rs1 value
reg2_i  in  DATA_W  rs2 value
imm_i  in  DATA_W  sign-extended immediate
pc_i  in  ADDR_W  instruction pc
bp_i  in  1  predicted taken
des_i  in  TAG_W  ROB destination tag
cdb_en_o  out  1  CDB3 broadcast valid
cdb_tag_o  out  TAG_W  CDB3 tag
cdb_data_o  out  DATA_W  link value (pc+4) or 0
jump_o  out  1  actual taken
target_o  out  ADDR_W  correct next pc
mispredict_o  out  1  prediction wrong; ROB redirects at commit
bpu_en_o  out  1  predictor update valid (conditional branches only)
bpu_pc_o  out  ADDR_W  pc to update
bpu_taken_o  out  1  outcome to train

Behaviour:
Clock and reset:
- One clock domain, clk.
- rst is synchronous active-high.
- rst or clear at a posedge: both stage-valid bits cleared and every output forced to 0.
- Any Branch_en_i sampled in that same cycle is dropped.
- rst/clear take priority over rdy.

Stall:
- rdy=0: no register changes. Outputs hold their previous values.
- Consumers qualify with rdy.
- Branch_en_i sampled while rdy=0 is ignored; the RS does not issue then.

Stage 1 (resolve), loaded when rdy=1. s1_valid<=Branch_en_i. Computed:
- Unsigned compares for BLTU/BGEU; signed compares for BLT/BGE.
- taken:
  - BEQ: reg1==reg2
  - BNE: reg1!=reg2
  - BLT: signed <
  - BGE: signed >=
  - BLTU: unsigned <
  - BGEU: unsigned >=
  - JAL, JALR: 1
  - any other op: 0
- target:
  - JAL, taken branch: pc+imm
  - JALR: (reg1+imm) & ~1
  - not-taken or unknown op: pc+4
- All adds wrap mod 2^ADDR_W.
- link = pc+4 for JAL/JALR, else 0.
- mispredict:
  - conditional branch: taken^bp
  - JAL: ~bp
  - JALR: 1 always; predictor holds no indirect targets
  - unknown op: 0
- Stage-1 fields (tag, taken, target, link, mispredict, is_cond, pc) registered.

Stage 2 (broadcast), loaded when rdy=1:
- Always: cdb_en_o<=s1_valid.
- If s1_valid: drive tag/data/jump/target/mispredict from stage 1.
- Else: all data outputs <=0.
- bpu_en_o<=s1_valid & is_cond; bpu_pc_o/bpu_taken_o from stage 1, else 0.

Timing and boundaries:
- Latency: issue at edge N → outputs valid after edge N+2. Throughput 1/cycle.
- Outputs are one-cycle pulses unless rdy=0 holds them.
- Back-to-back issues: each produces exactly one cdb_en_o pulse, in issue order, no bubbles.
- clear with both stages full: both results discarded. No CDB pulse for them, ever.
- Unknown op still broadcasts on CDB (data 0, mispredict 0) so the ROB entry completes.
- x0 operands arrive as value 0 from the RS; no special-casing here.

Test Plan:
- BEQ reg1=5 reg2=5 pc=0x100 imm=0x20 bp=0 tag=3 → two cycles later: cdb_en=1, tag=3, data=0, jump=1, target=0x120, mispredict=1, bpu_en=1, bpu_taken=1, bpu_pc=0x100.
- BLT reg1=0xFFFFFFFF reg2=1, and BLTU with the same operands, back-to-back, bp=1 both:
  - BLT → jump=1, mispredict=0.
  - BLTU (next cycle) → jump=0, target=pc+4, mispredict=1.
- JALR reg1=0x1003 imm=0x4 pc=0x200 bp=1 tag=7 → target=0x1006, data=0x204, jump=1, mispredict=1, bpu_en=0. Then JAL pc=0x300 imm=-8 bp=1 → target=0x2F8, data=0x304, mispredict=0.
- Issue BNE at cycle N, rdy=0 for cycles N+1..N+3 → outputs frozen; result appears one rdy-cycle after resume with correct values, exactly one pulse.
- Issue three ops back-to-back, assert clear with the third issue → the first op's result (already in the output register) is visible for one cycle, then all outputs 0. Exactly one cdb_en pulse is seen; no pulse for ops 2 and 3.
- rst asserted mid-stream with both stages full → next cycle all outputs 0. A subsequent BGEU 3>=3 resolves jump=1 normally.
